// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: opcodes, IR bubble constant, instruction layout.
package instruction_fetch_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 28;
    localparam int unsigned OP_W    = 8;
    localparam int unsigned FIELD_W = 8;

    // Opcodes shared with the execute stage
    localparam logic [OP_W-1:0] NOP = 8'h00;
    localparam logic [OP_W-1:0] JMP = 8'h0C;
    localparam logic [OP_W-1:0] BLE = 8'h0D;

    // Bubble placed in the IR on reset and on every redirect
    localparam logic [INSTR_W-1:0] IR_BUBBLE = {NOP, 20'h0_0000, 4'h0};

    // Instruction word layout as held in the IR
    typedef struct packed {
        logic [OP_W-1:0] operation;    // [27:20]
        logic [3:0]      destination;  // [19:16]
        logic [15:0]     literal;      // [15:0], also the two source address bytes
    } instr_t;

    // Sequential successor of a PC, 16-bit modulo
    function automatic logic [ADDR_W-1:0] pc_succ(input logic [ADDR_W-1:0] pc);
        return ADDR_W'(pc + ADDR_W'(1));
    endfunction

endpackage

// File: rtl/instruction_fetch_pc.sv
// Program counter: async reset, increment, external/local redirect and stall priority.
module fetch_pc
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              wLoad,
    input  logic [ADDR_W-1:0] wTarget,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_next;

    // Next PC: external redirect beats stall, stall beats local jump, else increment
    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = redirect_target;
        end else if (!stall) begin
            if (wLoad) begin
                pc_next = wTarget;
            end else begin
                pc_next = pc_succ(pc);
            end
        end
    end

    // PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives ROM address from the PC, registers the instruction into the IR
// and exposes its fields. Optional local JMP resolution is enabled by FETCH_JMP_EN.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'd0
) (
    input  logic                Clock,
    input  logic                Reset,
    output logic [ADDR_W-1:0]   oAddress,
    input  logic [INSTR_W-1:0]  iInstruction,
    input  logic                iStall,
    input  logic                iBranchTaken,
    input  logic [ADDR_W-1:0]   iBranchTarget,
    output logic                oValid,
    output logic [ADDR_W-1:0]   oPC,
    output logic [OP_W-1:0]     oOperation,
    output logic [FIELD_W-1:0]  oDestination,
    output logic [FIELD_W-1:0]  oSourceAddr1,
    output logic [FIELD_W-1:0]  oSourceAddr0,
    output logic [ADDR_W-1:0]   oLiteral
);

    instr_t            ir;
    logic              valid;
    logic [ADDR_W-1:0] ir_pc;
    logic [ADDR_W-1:0] pc;
    logic              wLoad;
    logic [ADDR_W-1:0] wTarget;

    // Local jump request: a valid JMP sitting in the IR
`ifdef FETCH_JMP_EN
    assign wLoad = valid && (ir.operation == JMP);
`else
    assign wLoad = 1'b0;
`endif
    assign wTarget = {8'b0, oDestination};

    fetch_pc #(
        .RESET_PC        (RESET_PC)
    ) u_pc (
        .clk             (Clock),
        .rst_n           (Reset),
        .stall           (iStall),
        .redirect        (iBranchTaken),
        .redirect_target (iBranchTarget),
        .wLoad           (wLoad),
        .wTarget         (wTarget),
        .pc              (pc)
    );

    // IR, its fetch address and valid flag; any redirect replaces the IR with a bubble
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ir    <= instr_t'(IR_BUBBLE);
            valid <= 1'b0;
            ir_pc <= '0;
        end else if (iBranchTaken) begin
            ir    <= instr_t'(IR_BUBBLE);
            valid <= 1'b0;
        end else if (!iStall) begin
            if (wLoad) begin
                ir    <= instr_t'(IR_BUBBLE);
                valid <= 1'b0;
            end else begin
                ir    <= instr_t'(iInstruction);
                ir_pc <= pc;
                valid <= 1'b1;
            end
        end
    end

    // Pure wiring from PC and IR to the outputs
    assign oAddress     = pc;
    assign oValid       = valid;
    assign oPC          = ir_pc;
    assign oOperation   = ir.operation;
    assign oDestination = {4'b0, ir.destination};
    assign oSourceAddr1 = ir.literal[15:8];
    assign oSourceAddr0 = ir.literal[7:0];
    assign oLiteral     = ir.literal;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small combinational ROM model.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic                Clock;
    logic                Reset;
    logic [ADDR_W-1:0]   oAddress;
    logic [INSTR_W-1:0]  iInstruction;
    logic                iStall;
    logic                iBranchTaken;
    logic [ADDR_W-1:0]   iBranchTarget;
    logic                oValid;
    logic [ADDR_W-1:0]   oPC;
    logic [OP_W-1:0]     oOperation;
    logic [FIELD_W-1:0]  oDestination;
    logic [FIELD_W-1:0]  oSourceAddr1;
    logic [FIELD_W-1:0]  oSourceAddr0;
    logic [ADDR_W-1:0]   oLiteral;

    int n_cmp;
    int n_bad;

    instruction_fetch #(.RESET_PC(16'd0)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .oAddress      (oAddress),
        .iInstruction  (iInstruction),
        .iStall        (iStall),
        .iBranchTaken  (iBranchTaken),
        .iBranchTarget (iBranchTarget),
        .oValid        (oValid),
        .oPC           (oPC),
        .oOperation    (oOperation),
        .oDestination  (oDestination),
        .oSourceAddr1  (oSourceAddr1),
        .oSourceAddr0  (oSourceAddr0),
        .oLiteral      (oLiteral)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ROM: address 15 holds JMP to 2, everything else {8'h01, 4'h3, addr}
    function automatic logic [INSTR_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        if (a == 16'd15) return {JMP, 4'h2, 16'h0000};
        return {8'h01, 4'h3, a};
    endfunction

    always_comb iInstruction = rom_word(oAddress);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        Reset = 1'b0;
        iStall = 1'b0;
        iBranchTaken = 1'b0;
        iBranchTarget = '0;

        // Reset state
        #3;
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_addr",  32'(oAddress), 32'd0);
        check("rst_op",    32'(oOperation), 32'(NOP));
        check("rst_pc",    32'(oPC), 32'd0);
        check("rst_lit",   32'(oLiteral), 32'd0);
        #9;
        Reset = 1'b1;
        check("rel_addr", 32'(oAddress), 32'd0);

        // Sequential fetch
        step();
        check("seq0_valid", 32'(oValid), 32'd1);
        check("seq0_pc",    32'(oPC), 32'd0);
        check("seq0_lit",   32'(oLiteral), 32'd0);
        check("seq0_addr",  32'(oAddress), 32'd1);
        step();
        check("seq1_pc",    32'(oPC), 32'd1);
        check("seq1_addr",  32'(oAddress), 32'd2);
        check("seq1_op",    32'(oOperation), 32'h01);
        check("seq1_dst",   32'(oDestination), 32'd3);
        step();
        check("seq2_src0",  32'(oSourceAddr0), 32'd2);
        check("seq2_src1",  32'(oSourceAddr1), 32'd0);
        check("seq2_addr",  32'(oAddress), 32'd3);
        step();
        step();
        check("pre_stall_addr", 32'(oAddress), 32'd5);
        check("pre_stall_pc",   32'(oPC), 32'd4);

        // Stall for three cycles at PC=5
        iStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr",  32'(oAddress), 32'd5);
            check("stall_pc",    32'(oPC), 32'd4);
            check("stall_valid", 32'(oValid), 32'd1);
        end
        iStall = 1'b0;
        step();
        check("unstall_pc",   32'(oPC), 32'd5);
        check("unstall_addr", 32'(oAddress), 32'd6);

        // Run up to address 15 (bounded)
        for (int i = 0; i < 40 && oAddress != 16'd15; i++) step();
        check("reach15", 32'(oAddress), 32'd15);
        step();
        check("jmp_ir_op",  32'(oOperation), 32'(JMP));
        check("jmp_ir_pc",  32'(oPC), 32'd15);
        check("jmp_ir_dst", 32'(oDestination), 32'd2);
        step();
`ifdef FETCH_JMP_EN
        check("jmp_bubble", 32'(oValid), 32'd0);
        check("jmp_addr",   32'(oAddress), 32'd2);
        step();
        check("jmp_tgt_pc",    32'(oPC), 32'd2);
        check("jmp_tgt_valid", 32'(oValid), 32'd1);
`else
        check("nojmp_valid", 32'(oValid), 32'd1);
        check("nojmp_pc",    32'(oPC), 32'd16);
        check("nojmp_addr",  32'(oAddress), 32'd17);
`endif

        // Taken branch overrides a simultaneous stall
        iBranchTaken = 1'b1;
        iBranchTarget = 16'd8;
        iStall = 1'b1;
        step();
        iBranchTaken = 1'b0;
        iStall = 1'b0;
        check("br_addr",  32'(oAddress), 32'd8);
        check("br_valid", 32'(oValid), 32'd0);
        step();
        check("br_tgt_pc",    32'(oPC), 32'd8);
        check("br_tgt_valid", 32'(oValid), 32'd1);
        check("br_tgt_lit",   32'(oLiteral), 32'd8);

        // PC wrap at 16'hFFFF
        iBranchTaken = 1'b1;
        iBranchTarget = 16'hFFFF;
        step();
        iBranchTaken = 1'b0;
        check("wrap_pre", 32'(oAddress), 32'hFFFF);
        step();
        check("wrap_addr", 32'(oAddress), 32'd0);
        check("wrap_pc",   32'(oPC), 32'hFFFF);
        check("wrap_lit",  32'(oLiteral), 32'hFFFF);
        check("wrap_valid", 32'(oValid), 32'd1);

        // Asynchronous reset mid-stream
        #2;
        Reset = 1'b0;
        #1;
        check("arst_valid", 32'(oValid), 32'd0);
        check("arst_op",    32'(oOperation), 32'(NOP));
        check("arst_lit",   32'(oLiteral), 32'd0);
        check("arst_addr",  32'(oAddress), 32'd0);
        Reset = 1'b1;
        step();
        check("post_arst_pc",    32'(oPC), 32'd0);
        check("post_arst_valid", 32'(oValid), 32'd1);
        check("post_arst_addr",  32'(oAddress), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
